// File: rtl/sodor_state_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sodor_state_scan_pkg                                                 |
// | Shared types and image sizes for the Sodor state-diff scanner.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sodor_state_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Register file image: 32 x 32-bit words.
    localparam int REGFILE_WORDS = 32;
    localparam int REGFILE_WIDTH = 32;

    localparam int CSR_WORDS = 16;
    localparam int CSR_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/sodor_state_word_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sodor_state_word_sel                                                 |
// | Combinational word-select mux over a flattened state image.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sodor_state_word_sel #(
    parameter int WORDS = 32,
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WORDS)
) (
    input  logic [WORDS*WIDTH-1:0] image_i,
    input  logic [IDXW-1:0]        idx_i,
    output logic [WIDTH-1:0]       word_o
);

    logic [WIDTH-1:0] w_words [WORDS];

    for (genvar g = 0; g < WORDS; g++) begin : g_unpack
        assign w_words[g] = image_i[g*WIDTH +: WIDTH];
    end

    assign word_o = w_words[idx_i];

endmodule
`default_nettype wire

// File: rtl/sodor_state_diff_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sodor_state_diff_scanner                                             |
// | Walks two state images word by word and reports mismatch results.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sodor_state_diff_scanner
    import sodor_state_scan_pkg::*;
#(
    parameter int WORDS = REGFILE_WORDS,
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int IDXW  = $clog2(WORDS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [WORDS*WIDTH-1:0] state_src_i,
    input  logic [WORDS*WIDTH-1:0] state_trg_i,
    input  logic [WORDS-1:0]       skip_mask_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   equal_o,
    output logic [IDXW:0]          mismatch_count_o,
    output logic [IDXW-1:0]        first_idx_o,
    output logic                   first_valid_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW:0]   CNT_ONE  = (IDXW + 1)'(1);

    scan_state_e         state_q;
    logic [IDXW-1:0]     idx_q;
    logic [IDXW:0]       count_q;
    logic [IDXW-1:0]     first_idx_q;
    logic                first_valid_q;
    logic                equal_q;
    logic                busy_q;
    logic                done_q;

    logic [WIDTH-1:0]    w_src_word;
    logic [WIDTH-1:0]    w_trg_word;
    logic                hit_d;
    logic [IDXW:0]       count_d;
    logic [IDXW-1:0]     idx_d;

    sodor_state_word_sel #(.WORDS(WORDS), .WIDTH(WIDTH), .IDXW(IDXW)) u_sel_src (
        .image_i (state_src_i),
        .idx_i   (idx_q),
        .word_o  (w_src_word)
    );

    sodor_state_word_sel #(.WORDS(WORDS), .WIDTH(WIDTH), .IDXW(IDXW)) u_sel_trg (
        .image_i (state_trg_i),
        .idx_i   (idx_q),
        .word_o  (w_trg_word)
    );

    assign hit_d   = (w_src_word != w_trg_word) && !skip_mask_i[idx_q];
    assign count_d = count_q + CNT_ONE;
    assign idx_d   = idx_q + IDX_ONE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            count_q       <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
            equal_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort beats everything, including a simultaneous start in IDLE.
            if (abort_i) begin
                state_q       <= ST_IDLE;
                idx_q         <= '0;
                count_q       <= '0;
                first_idx_q   <= '0;
                first_valid_q <= 1'b0;
                equal_q       <= 1'b0;
                busy_q        <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            state_q       <= ST_SCAN;
                            idx_q         <= '0;
                            count_q       <= '0;
                            first_idx_q   <= '0;
                            first_valid_q <= 1'b0;
                            equal_q       <= 1'b0;
                            busy_q        <= 1'b1;
                        end
                    end
                    ST_SCAN: begin
                        if (hit_d) begin
                            count_q <= count_d;
                            if (!first_valid_q) begin
                                first_idx_q   <= idx_q;
                                first_valid_q <= 1'b1;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                    ST_DONE: begin
                        equal_q <= (count_q == '0);
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign equal_o          = equal_q;
    assign mismatch_count_o = count_q;
    assign first_idx_o      = first_idx_q;
    assign first_valid_o    = first_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sodor_state_diff_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sodor_state_diff_scanner                                          |
// | Self-checking bench with a word-level reference model.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sodor_state_diff_scanner;

    localparam int NW = 32;
    localparam int WD = 32;
    localparam int IW = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [NW*WD-1:0]  src;
    logic [NW*WD-1:0]  trg;
    logic [NW-1:0]     mask;
    logic              busy;
    logic              done;
    logic              equal;
    logic [IW:0]       mcount;
    logic [IW-1:0]     fidx;
    logic              fvalid;

    int total = 0;
    int bad   = 0;

    sodor_state_diff_scanner dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .abort_i          (abort),
        .state_src_i      (src),
        .state_trg_i      (trg),
        .skip_mask_i      (mask),
        .busy_o           (busy),
        .done_o           (done),
        .equal_o          (equal),
        .mismatch_count_o (mcount),
        .first_idx_o      (fidx),
        .first_valid_o    (fvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count differing unmasked words and find the lowest one.
    task automatic ref_model(input logic [NW*WD-1:0] s, input logic [NW*WD-1:0] t,
                             input logic [NW-1:0] m, output int cnt, output int first,
                             output bit fv);
        cnt = 0; first = 0; fv = 0;
        for (int i = 0; i < NW; i++) begin
            if (s[i*WD +: WD] != t[i*WD +: WD] && !m[i]) begin
                cnt++;
                if (!fv) begin first = i; fv = 1; end
            end
        end
    endtask

    task automatic run_scan(input logic [NW*WD-1:0] s, input logic [NW*WD-1:0] t,
                            input logic [NW-1:0] m, input string tag);
        int  exp_cnt, exp_first, done_at, done_n, busy_low;
        bit  exp_fv;
        ref_model(s, t, m, exp_cnt, exp_first, exp_fv);
        src = s; trg = t; mask = m; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_at = -1; done_n = 0; busy_low = 0;
        for (int k = 1; k <= NW + 2; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k <= NW + 1 && busy !== 1'b1) busy_low++;
            if (k == NW + 1) begin
                total++;
                if (mcount !== (IW+1)'(exp_cnt)) begin
                    bad++; $display("FAIL %s count: got %0d want %0d", tag, mcount, exp_cnt);
                end
                total++;
                if (fvalid !== exp_fv) begin
                    bad++; $display("FAIL %s first_valid: got %0b want %0b", tag, fvalid, exp_fv);
                end
                total++;
                if (fidx !== IW'(exp_first)) begin
                    bad++; $display("FAIL %s first_idx: got %0d want %0d", tag, fidx, exp_first);
                end
            end
            if (k == NW + 2) begin
                total++;
                if (equal !== (exp_cnt == 0)) begin
                    bad++; $display("FAIL %s equal: got %0b want %0b", tag, equal, exp_cnt == 0);
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL %s busy_after: got %0b want 0", tag, busy);
                end
            end
        end
        total++;
        if (done_n != 1 || done_at != NW + 1) begin
            bad++; $display("FAIL %s done_timing: got %0d pulses at %0d want 1 at %0d",
                            tag, done_n, done_at, NW + 1);
        end
        total++;
        if (busy_low != 0) begin
            bad++; $display("FAIL %s busy_during: got %0d low cycles want 0", tag, busy_low);
        end
    endtask

    task automatic rand_image(output logic [NW*WD-1:0] img);
        for (int i = 0; i < NW; i++) img[i*WD +: WD] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; src = '0; trg = '0; mask = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, equal, mcount, fidx, fvalid} !== '0) begin
            bad++; $display("FAIL reset_values: got %b want 0", {busy, done, equal, mcount, fidx, fvalid});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [NW*WD-1:0] a, b;
        rand_image(a);
        run_scan(a, a, '0, "identical");
        b = a; b[5*WD +: WD] = ~a[5*WD +: WD]; b[20*WD +: WD] = a[20*WD +: WD] ^ 32'h1;
        run_scan(a, b, '0, "two_diffs");
        b = a; b[0 +: WD] = ~a[0 +: WD];
        run_scan(a, b, 32'h1, "masked_w0");
        b[31*WD +: WD] = ~a[31*WD +: WD];
        run_scan(a, b, 32'h1, "masked_w0_w31");
    endtask

    task automatic test_abort();
        logic [NW*WD-1:0] a, b;
        int dn;
        rand_image(a);
        run_scan(a, a, '0, "pre_abort");
        b = a; b[1*WD +: WD] = ~a[1*WD +: WD]; b[3*WD +: WD] = ~a[3*WD +: WD];
        src = a; trg = b; mask = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, equal, mcount, fvalid} !== '0) begin
            bad++; $display("FAIL abort_clear: got busy=%0b equal=%0b count=%0d fv=%0b want 0",
                            busy, equal, mcount, fvalid);
        end
        dn = 0;
        repeat (NW + 4) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        total++;
        if (dn != 0) begin
            bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dn);
        end
        run_scan(a, b, '0, "post_abort");
    endtask

    task automatic test_back_to_back();
        int dn, wrong_at;
        logic [NW*WD-1:0] a, b;
        rand_image(a);
        src = a; trg = a; mask = '0;
        dn = 0; wrong_at = 0;
        start = 1'b1;
        for (int k = 1; k <= 3 * (NW + 2); k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dn++;
                if ((k - (NW + 1)) % (NW + 2) != 0) wrong_at++;
            end
        end
        start = 1'b0;
        total++;
        if (dn != 3 || wrong_at != 0) begin
            bad++; $display("FAIL start_spam: got %0d dones (%0d misplaced) want 3 (0)", dn, wrong_at);
        end
        // Non-clean run so start+abort must visibly clear results.
        b = a; b[7*WD +: WD] = ~a[7*WD +: WD];
        run_scan(a, b, '0, "pre_start_abort");
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        dn = 0;
        repeat (NW + 4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        total++;
        if (dn != 0 || {equal, mcount, fidx, fvalid} !== '0) begin
            bad++; $display("FAIL start_abort_idle: got active=%0d count=%0d fv=%0b want 0 0 0",
                            dn, mcount, fvalid);
        end
    endtask

    task automatic test_reset_midscan();
        logic [NW*WD-1:0] a, b;
        rand_image(a);
        b = a; b[2*WD +: WD] = ~a[2*WD +: WD];
        src = a; trg = b; mask = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, equal, mcount, fidx, fvalid} !== '0) begin
            bad++; $display("FAIL async_reset: got %b want 0", {busy, done, equal, mcount, fidx, fvalid});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got busy=%0b want 0", busy);
        end
        run_scan(a, a, '0, "after_reset");
    endtask

    task automatic test_random();
        logic [NW*WD-1:0] a, b;
        logic [NW-1:0]    m;
        int n, w;
        for (int it = 0; it < 8; it++) begin
            rand_image(a);
            b = a;
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                w = $urandom_range(0, NW - 1);
                b[w*WD +: WD] = a[w*WD +: WD] ^ ($urandom | 32'h1);
            end
            m = (it % 2 == 0) ? '0 : ($urandom & $urandom);
            run_scan(a, b, m, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_reset_midscan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sodor_state_diff_scanner.md
# sodor_state_diff_scanner

Sequencing controller for the flattened architectural-state vectors of the 2-stage Sodor core, such as the 1024-bit register file image. On a start request it walks two equal-width state images (source and target copy) one WIDTH-bit word per cycle. It reports whether they match, how many words differ, and the index of the first differing word. It sits beside the per-copy state extraction logic in the multi-way leakage bench and is the only block that sequences reads of those flattened vectors.

## Interface
- WORDS, default 32: number of words per state image.
- WIDTH, default 32: bits per word.
- IDXW, default $clog2(WORDS): index width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  scan request; accepted only while busy=0.
- abort  in  1  cancel the scan in progress.
- state_src  in  WORDS*WIDTH  source image; word i is bits [i*WIDTH +: WIDTH].
- state_trg  in  WORDS*WIDTH  target image, same layout.
- skip_mask  in  WORDS  bit i=1 excludes word i from comparison (e.g. x0).
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse in the DONE state.
- equal  out  1  1 iff the last completed scan found zero unmasked mismatches.
- mismatch_count  out  IDXW+1  unmasked mismatching words in the last or current scan.
- first_idx  out  IDXW  lowest mismatching unmasked word index.
- first_valid  out  1  first_idx is meaningful.
- Reset values: busy=0, done=0, equal=0, mismatch_count=0, first_idx=0, first_valid=0. The FSM resets to IDLE with idx=0.

## Operation
FSM has three states: IDLE, SCAN, DONE.

- IDLE:
  - start=1 and abort=0: idx<=0, mismatch_count<=0, first_valid<=0, first_idx<=0, equal<=0, go to SCAN.
  - start=1 and abort=1 together: abort wins. Stay in IDLE; results are cleared exactly as on an accepted abort.
- SCAN, each cycle:
  - Compare word idx of state_src and state_trg.
  - Mismatch and skip_mask[idx]=0: mismatch_count increments. If first_valid=0, also set first_idx<=idx and first_valid<=1.
  - Masked words never count, even if they differ.
  - idx==WORDS-1: go to DONE. Otherwise idx<=idx+1.
  - No wrap past WORDS-1.
- DONE:
  - done=1 for exactly one cycle.
  - equal<=(mismatch_count==0), registered on the DONE→IDLE edge. equal therefore reads 1 from the first IDLE cycle after a clean scan.
  - Always return to IDLE.
- abort in SCAN or DONE: go to IDLE, no done pulse. equal, mismatch_count, first_valid and first_idx are cleared.
- start while busy=1 is ignored; no queuing.
- Results hold in IDLE until the next accepted start, an abort, or reset.
- mismatch_count cannot overflow: IDXW+1 bits hold WORDS.
- Inputs are sampled live each SCAN cycle. The requester holds state_src, state_trg and skip_mask stable while busy=1. Words changed mid-scan are compared with whatever value they hold in their own scan cycle.
- Reset mid-scan: immediate return to IDLE with all outputs at their reset values.

## Timing
- start accepted at edge T.
- SCAN occupies cycles T+1 to T+WORDS.
- DONE (done=1) is cycle T+WORDS+1, so latency from start to done is WORDS+1 cycles.
- busy is high for cycles T+1 to T+WORDS+1.
- equal is valid from cycle T+WORDS+2.
- mismatch_count, first_idx and first_valid are final in the DONE cycle.
- Earliest next accepted start is the edge ending cycle T+WORDS+1's successor, i.e. the first cycle with busy=0.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package sodor_state_scan_pkg holds:
  - the state typedef (enum IDLE/SCAN/DONE, 2 bits);
  - default WORDS/WIDTH constants for the regfile image (32×32);
  - constants for the CSR image word count, so other benches size instances consistently.
- Sub-module sodor_state_word_sel holds the parameterized combinational word-select mux, indexed by idx and instantiated once per image.
- The FSM, counters and result registers live in the top module.

## Test plan
- Identical images of 32 words, mask=0, start pulse → done in cycle T+33, equal=1, mismatch_count=0, first_valid=0.
- Words 5 and 20 differ, mask=0 → mismatch_count=2, first_idx=5, first_valid=1, equal=0.
- Word 0 differs, skip_mask=32'h1 → equal=1, count=0. Then word 0 and word 31 differ with the same mask → count=1, first_idx=31.
- Abort asserted in cycle T+10 → busy=0 next cycle, no done pulse, count=0, equal=0. A new start is then accepted normally.
- start repeated every cycle during a scan → exactly one done per WORDS+2 cycles. start together with abort in IDLE → no scan.
- Reset asserted mid-SCAN (asynchronously, between edges) → all outputs 0 immediately, FSM in IDLE. After deassertion a clean scan completes with done at WORDS+1.
